// File: rtl/hdmi_overlay_pkg.sv
// Shared definitions for the frame-counter overlay.
// Holds the 7-segment bit assignments, the glyph cell geometry in glyph
// units, the BCD-to-segment decoder, and the per-unit segment hit test.
package hdmi_overlay_pkg;

  // Bit positions inside seg7_t.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyph cell geometry, in glyph units.
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 14;
  localparam int SPACE_COL = 7;
  localparam int SPACE_ROW = 13;

  typedef logic [6:0] seg7_t;

  // Nibbles 10..15 cannot come out of a BCD counter; they decode blank.
  function automatic seg7_t bcd_to_seg7(input logic [3:0] bcd);
    seg7_t s;
    case (bcd)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // True when local unit (lx, ly) lies on a segment that is lit in segs.
  function automatic logic seg_hit(input seg7_t segs, input logic [2:0] lx,
                                   input logic [3:0] ly);
    logic mid_x;
    logic top_y;
    logic bot_y;
    logic hit;
    mid_x = (lx >= 3'd1) && (lx <= 3'd5);
    top_y = (ly >= 4'd1) && (ly <= 4'd5);
    bot_y = (ly >= 4'd7) && (ly <= 4'd11);
    hit = (segs[SEG_A] && mid_x && (ly == 4'd0))
        | (segs[SEG_B] && (lx == 3'd6) && top_y)
        | (segs[SEG_C] && (lx == 3'd6) && bot_y)
        | (segs[SEG_D] && mid_x && (ly == 4'd12))
        | (segs[SEG_E] && (lx == 3'd0) && bot_y)
        | (segs[SEG_F] && (lx == 3'd0) && top_y)
        | (segs[SEG_G] && mid_x && (ly == 4'd6));
    // Spacing column/row are already excluded by the ranges above; the
    // explicit guard keeps that true if segment extents are ever edited.
    return hit && (lx != 3'(SPACE_COL)) && (ly != 4'(SPACE_ROW));
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// DIGITS-wide ripple BCD counter.
// Ports: clk_i / rst_ni (async active-low), clear_i (sync clear, wins over
// inc_i), inc_i (add one), count_o (digit 0 = most significant, top nibble).
// All-9s wraps to all-0s silently.
module bcd_counter
  import hdmi_overlay_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [4*DIGITS-1:0] count_o
);

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic                carry;

  // k = 0 is the least significant digit (bottom nibble); carry ripples up.
  always_comb begin
    count_d = count_q;
    carry   = inc_i;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          count_d[4*k +: 4] = 4'd0;
        end else begin
          count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clear_i) count_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_overlay.sv
// Frame counter overlay: draws a BCD frame count as scaled 7-segment glyphs
// over the background pixel stream feeding the HDMI transmitter.
// Ports: clk_pixel, reset_n (async active-low), cx/cy frame coordinates,
// rgb_in background pixel, run (count enable), clear (sync clear),
// rgb composited pixel (2-cycle latency), count (BCD, digit 0 in top nibble).
module counter_overlay
  import hdmi_overlay_pkg::*;
#(
  parameter int          BIT_WIDTH  = 9,
  parameter int          BIT_HEIGHT = 9,
  parameter int          DIGITS     = 6,
  parameter int          ORIGIN_X   = 200,
  parameter int          ORIGIN_Y   = 100,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [23:0] FG         = 24'hFFFFFF
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [BIT_WIDTH:0]    cx,
  input  logic [BIT_HEIGHT:0]   cy,
  input  logic [23:0]           rgb_in,
  input  logic                  run,
  input  logic                  clear,
  output logic [23:0]           rgb,
  output logic [4*DIGITS-1:0]   count
);

  localparam int XW    = BIT_WIDTH + 2;
  localparam int YW    = BIT_HEIGHT + 2;
  localparam int BOX_W = (CELL_W * DIGITS) << SCALE_LOG2;
  localparam int BOX_H = CELL_H << SCALE_LOG2;

  localparam logic signed [XW-1:0] OX    = XW'(ORIGIN_X);
  localparam logic signed [YW-1:0] OY    = YW'(ORIGIN_Y);
  localparam logic signed [XW-1:0] BOX_WS = XW'(BOX_W);
  localparam logic signed [YW-1:0] BOX_HS = YW'(BOX_H);
  // When the box extent does not fit the signed local range, every
  // non-negative offset is inside; the compare is then skipped.
  localparam bit WIDE_X = BOX_W >= 2**(XW-1);
  localparam bit WIDE_Y = BOX_H >= 2**(YW-1);

  // Frame counter
  logic frame_start;
  logic [4*DIGITS-1:0] count_q;

  assign frame_start = (cx == '0) && (cy == '0);

  bcd_counter #(.DIGITS(DIGITS)) u_bcd_counter (
    .clk_i   (clk_pixel),
    .rst_ni  (reset_n),
    .clear_i (clear),
    .inc_i   (frame_start && run),
    .count_o (count_q)
  );

  assign count = count_q;

  // Stage 1: local coordinates and box test
  logic signed [XW-1:0] rx;
  logic signed [YW-1:0] ry;
  logic                 inbox_d;
  logic [2:0]           dig_d;
  logic [2:0]           lx_d;
  logic [3:0]           ly_d;

  assign rx = $signed({1'b0, cx}) - OX;
  assign ry = $signed({1'b0, cy}) - OY;

  assign inbox_d = !rx[XW-1] && (WIDE_X || (rx < BOX_WS))
                && !ry[YW-1] && (WIDE_Y || (ry < BOX_HS));
  // Shift-then-slice done as a direct slice: ux = rx >> SCALE_LOG2.
  assign dig_d = rx[SCALE_LOG2+5 : SCALE_LOG2+3];
  assign lx_d  = rx[SCALE_LOG2+2 : SCALE_LOG2];
  assign ly_d  = ry[SCALE_LOG2+3 : SCALE_LOG2];

  logic        inbox_q;
  logic [2:0]  dig_q;
  logic [2:0]  lx_q;
  logic [3:0]  ly_q;
  logic [23:0] bg_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      inbox_q <= 1'b0;
      dig_q   <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      bg_q    <= '0;
    end else begin
      inbox_q <= inbox_d;
      dig_q   <= dig_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      bg_q    <= rgb_in;
    end
  end

  // Stage 2: digit select, decode, hit test, composite
  logic [3:0]  nib;
  logic        hit;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == 3'(i)) nib = count_q[4*(DIGITS-1-i) +: 4];
    end
  end

  assign hit   = seg_hit(bcd_to_seg7(nib), lx_q, ly_q);
  assign rgb_d = (inbox_q && hit) ? FG : bg_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule
